riscv_lsu_ctrl: RTL and testbench
=================================

# riscv_lsu_ctrl

Load/store controller between the core's execute stage and the data-memory port. It accepts the memory request, size and write flags produced by instruction decode, plus the ALU address and the rs2 data. It then sequences one bus transaction per instruction with a ready handshake, stalling the core until the transaction completes. It also generates byte enables and write-data replication, sign/zero-extends load data, and flags misaligned accesses and bus timeouts.

## Interface
- `TIMEOUT`, default 255: maximum number of ACCESS cycles to wait for `mem_ready_i`. A value of 0 disables the timeout.
- `clk_i` in 1: clock. All state updates on the rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `core_req_i` in 1: memory instruction present. Mirrors decode `mem_req`.
- `core_we_i` in 1: 1 means store, 0 means load.
- `core_size_i` in 3: 0=B, 1=H, 2=W, 4=BU, 5=HU. Codes 3, 6 and 7 are invalid.
- `core_addr_i` in 32: byte address from the ALU.
- `core_wd_i` in 32: store data (rs2).
- `core_rd_o` out 32: extended load data.
- `core_stall_o` out 1: hold the pipeline.
- `misalign_o` out 1: misaligned access or invalid size. Combinational.
- `bus_err_o` out 1: one-cycle timeout pulse.
- `mem_req_o` out 1: bus request.
- `mem_we_o` out 1: bus write.
- `mem_be_o` out 4: byte enables.
- `mem_addr_o` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wd_o` out 32: replicated write data.
- `mem_rd_i` in 32: bus read data, valid when `mem_ready_i` is high.
- `mem_ready_i` in 1: transaction complete.

## Operation
- FSM has three states: IDLE, ACCESS, RESP.
- Fault condition `misalign_o = core_req_i & state==IDLE & f`, where `f` is any of:
  - half access (size 1 or 5) with `addr[0]` set;
  - word access (size 2) with `addr[1:0] != 0`;
  - an invalid size code.
- A faulting request never leaves IDLE, never asserts `mem_req_o`, and never stalls. Trap handling belongs to the core.
- IDLE → ACCESS: on `core_req_i & ~f`. The controller latches `we`, `size`, `addr` and `wd` into internal registers and clears the timeout counter.
- ACCESS:
  - `mem_req_o=1`. `mem_we_o`, `mem_be_o`, `mem_addr_o` and `mem_wd_o` are driven from the latched registers and stay stable until ready.
  - Counter increments each cycle.
  - On `mem_ready_i`: capture `mem_rd_i` into the read register and go to RESP.
  - On counter reaching `TIMEOUT-1` without ready (only when `TIMEOUT≠0`): set the read register to 0, pulse `bus_err_o` on the RESP cycle, and go to RESP.
- RESP → IDLE unconditionally. `core_stall_o=0` for this cycle, so the core retires the instruction.
- `core_stall_o = (state==IDLE & core_req_i & ~f) | state==ACCESS`.
- Byte enables:
  - B/BU: `4'b0001 << addr[1:0]`;
  - H/HU: `4'b0011 << {addr[1],1'b0}`;
  - W: `4'b1111`.
- Write data: B uses `{4{wd[7:0]}}`, H uses `{2{wd[15:0]}}`, W uses `wd`.
- Load data: select the byte or half by the latched `addr[1:0]` from the read register.
  - B/H are sign-extended; BU/HU are zero-extended; W is passed through.
  - Stores return `core_rd_o=0`.
- Outside ACCESS, the bus outputs are 0.

## Timing
- Reset (async, immediate): state=IDLE; counter=0; read register=0.
  - `mem_req_o`, `mem_we_o` and `bus_err_o` = 0; `mem_be_o`, `mem_addr_o` and `mem_wd_o` = 0.
  - `core_rd_o` = 0; `core_stall_o` follows its combinational formula.
- Reset asserted during ACCESS drops `mem_req_o` without waiting for the edge. Any pending response is discarded.
- Latency is 2 + N cycles from request to retire, where N is the number of ACCESS cycles before ready.
  - Zero-wait memory (ready in the first ACCESS cycle) gives the sequence IDLE(stall) → ACCESS(stall) → RESP(no stall).
- `mem_ready_i` is ignored outside ACCESS.
- A `core_req_i` seen in RESP is not a new request; new requests are sampled only in IDLE.
- Back-to-back memory instructions: the second request starts in the IDLE cycle that follows RESP.
- Timeout boundary: with `TIMEOUT=T` and no ready, ACCESS lasts exactly T cycles. Ready arriving in the T-th cycle wins over the timeout.

## Test plan
- LW at `0x100`, `mem_rd_i=0xDEADBEEF`, ready on the first ACCESS cycle: stall is high for 2 cycles; `mem_be_o=1111`, `mem_addr_o=0x100`; in RESP `core_rd_o=0xDEADBEEF`, stall=0.
- LB at `0x203`, `mem_rd_i=0x80FF_FFFF`: `mem_be_o=1000`, `mem_addr_o=0x200`, `core_rd_o=0xFFFF_FF80`. The same access as LBU gives `0x0000_0080`.
- SH at `0x102`, `wd=0x1234_ABCD`, ready after 3 wait cycles: `mem_we_o=1`, `mem_be_o=1100`, `mem_wd_o=0xABCD_ABCD` held stable for 4 ACCESS cycles; stall for 5 cycles total.
- LW at `0x101` and LH at `0x003`: `misalign_o=1` in the same cycle, `mem_req_o` stays 0, stall=0. Size code 3 gives the same result.
- `TIMEOUT=4` with ready held low: ACCESS lasts 4 cycles, then RESP with `bus_err_o=1` for 1 cycle and `core_rd_o=0`. Repeating with ready on the 4th cycle gives no error and returns the data.
- `rst_ni` driven low mid-ACCESS (between clock edges): `mem_req_o` falls immediately; after release the FSM is in IDLE and the next LW completes normally.

Source files
------------

// File: rtl/riscv_lsu_ctrl.sv
// riscv_lsu_ctrl: load/store sequencer between the execute stage and the data-memory port.
// Runs one bus transaction per memory instruction (IDLE -> ACCESS -> RESP) and stalls the core
// while the transaction is in flight.
// It forms byte enables, replicates store data and sign/zero-extends load data.
// It flags misaligned or invalid-size requests combinationally and reports a bus timeout
// with a one-cycle pulse.
// Latency: 2 + N cycles from request to retire (N = ACCESS cycles until mem_ready_i).
// Backpressure: mem_ready_i ends ACCESS; core_stall_o is held until the RESP cycle.
// Ports:
//   clk_i, rst_ni                   clock, async active-low reset
//   core_req_i/we_i/size_i/addr_i/wd_i  request from decode/ALU/rs2
//   core_rd_o                       extended load data (0 for stores)
//   core_stall_o                    pipeline hold
//   misalign_o                      misaligned access or invalid size (combinational)
//   bus_err_o                       one-cycle timeout pulse in RESP
//   mem_req_o/we_o/be_o/addr_o/wd_o bus request, zero outside ACCESS
//   mem_rd_i, mem_ready_i           bus read data and completion
module riscv_lsu_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_o,
   output logic        misalign_o,
   output logic        bus_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ready_i
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam bit          TO_EN = (TIMEOUT != 0);
   localparam logic [31:0] TLAST = TIMEOUT - 32'd1;

   state_t      state;
   logic        lat_we;
   logic [2:0]  lat_size;
   logic [1:0]  lat_off;
   logic [31:0] cnt;
   logic [31:0] rdata;

   logic        fault;
   logic        accept;
   logic [3:0]  be_next;
   logic [31:0] wd_next;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Request decode: fault detection, byte enables and write-data replication.
   always_comb begin
      fault   = 1'b0;
      be_next = 4'b0000;
      wd_next = core_wd_i;
      case (core_size_i)
         3'd0, 3'd4: begin
            be_next = 4'b0001 << core_addr_i[1:0];
            wd_next = {4{core_wd_i[7:0]}};
         end
         3'd1, 3'd5: begin
            fault   = core_addr_i[0];
            be_next = 4'b0011 << {core_addr_i[1], 1'b0};
            wd_next = {2{core_wd_i[15:0]}};
         end
         3'd2: begin
            fault   = (core_addr_i[1:0] != 2'b00);
            be_next = 4'b1111;
         end
         default: fault = 1'b1;
      endcase
   end

   assign accept       = core_req_i & (state == IDLE) & ~fault;
   assign misalign_o   = core_req_i & (state == IDLE) & fault;
   assign core_stall_o = accept | (state == ACCESS);

   // Load-data lane selection uses the address latched at request time.
   always_comb begin
      case (lat_off)
         2'd0:    sel_byte = rdata[7:0];
         2'd1:    sel_byte = rdata[15:8];
         2'd2:    sel_byte = rdata[23:16];
         default: sel_byte = rdata[31:24];
      endcase
      sel_half = lat_off[1] ? rdata[31:16] : rdata[15:0];
      if (lat_we) begin
         core_rd_o = 32'd0;
      end else begin
         case (lat_size)
            3'd0:    core_rd_o = {{24{sel_byte[7]}}, sel_byte};
            3'd4:    core_rd_o = {24'd0, sel_byte};
            3'd1:    core_rd_o = {{16{sel_half[15]}}, sel_half};
            3'd5:    core_rd_o = {16'd0, sel_half};
            default: core_rd_o = rdata;
         endcase
      end
   end

   // Single FSM block; bus outputs are registered so they are stable through ACCESS
   // and are cleared asynchronously by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= IDLE;
         lat_we     <= 1'b0;
         lat_size   <= 3'd0;
         lat_off    <= 2'd0;
         cnt        <= 32'd0;
         rdata      <= 32'd0;
         bus_err_o  <= 1'b0;
         mem_req_o  <= 1'b0;
         mem_we_o   <= 1'b0;
         mem_be_o   <= 4'b0000;
         mem_addr_o <= 32'd0;
         mem_wd_o   <= 32'd0;
      end else begin
         bus_err_o <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state      <= ACCESS;
                  lat_we     <= core_we_i;
                  lat_size   <= core_size_i;
                  lat_off    <= core_addr_i[1:0];
                  cnt        <= 32'd0;
                  mem_req_o  <= 1'b1;
                  mem_we_o   <= core_we_i;
                  mem_be_o   <= be_next;
                  mem_addr_o <= {core_addr_i[31:2], 2'b00};
                  mem_wd_o   <= wd_next;
               end
            end
            ACCESS: begin
               cnt <= cnt + 32'd1;
               // Ready in the last allowed cycle takes priority over the timeout.
               if (mem_ready_i || (TO_EN && (cnt == TLAST))) begin
                  state      <= RESP;
                  rdata      <= mem_ready_i ? mem_rd_i : 32'd0;
                  bus_err_o  <= ~mem_ready_i;
                  mem_req_o  <= 1'b0;
                  mem_we_o   <= 1'b0;
                  mem_be_o   <= 4'b0000;
                  mem_addr_o <= 32'd0;
                  mem_wd_o   <= 32'd0;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
module tb_riscv_lsu_ctrl;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        core_req;
   logic        core_we;
   logic [2:0]  core_size;
   logic [31:0] core_addr;
   logic [31:0] core_wd;
   logic [31:0] core_rd;
   logic        core_stall;
   logic        misalign;
   logic        bus_err;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;
   logic        mem_ready;

   int n_chk  = 0;
   int n_fail = 0;

   riscv_lsu_ctrl #(.TIMEOUT(T)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .core_req_i   (core_req),
      .core_we_i    (core_we),
      .core_size_i  (core_size),
      .core_addr_i  (core_addr),
      .core_wd_i    (core_wd),
      .core_rd_o    (core_rd),
      .core_stall_o (core_stall),
      .misalign_o   (misalign),
      .bus_err_o    (bus_err),
      .mem_req_o    (mem_req),
      .mem_we_o     (mem_we),
      .mem_be_o     (mem_be),
      .mem_addr_o   (mem_addr),
      .mem_wd_o     (mem_wd),
      .mem_rd_i     (mem_rd),
      .mem_ready_i  (mem_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model (byte-lane arithmetic) ----------------
   function automatic int nbytes(input logic [2:0] s);
      case (s)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         3'd2:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic bit is_fault(input logic [2:0] s, input logic [31:0] a);
      int n = nbytes(s);
      if (n == 0) return 1'b1;
      return (int'(a[1:0]) % n) != 0;
   endfunction

   function automatic logic [31:0] model_be(input logic [2:0] s, input logic [31:0] a);
      logic [31:0] be = 0;
      int off = int'(a[1:0]);
      int n = nbytes(s);
      for (int i = 0; i < 4; i++)
         if (i >= off && i < off + n) be[i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] model_wd(input logic [2:0] s, input logic [31:0] wd);
      logic [31:0] r = 0;
      int n = nbytes(s);
      for (int i = 0; i < 4; i++)
         r = r | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
      return r;
   endfunction

   function automatic logic [31:0] model_rd(input logic [2:0] s, input logic [31:0] a,
                                            input logic [31:0] rd);
      int n = nbytes(s);
      int off = int'(a[1:0]);
      longint v, lim;
      if (n == 4) return rd;
      lim = longint'(1) << (8 * n);
      v = longint'(rd >> (8 * off)) & (lim - 1);
      if (s < 3'd4 && v >= (lim >> 1)) v = v - lim;
      return 32'(v);
   endfunction

   // One complete accepted transaction. Entered and left in IDLE, a few ns after a rising edge.
   task automatic txn(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rd, input int wait_n,
                      input string tag);
      bit timed_out = (wait_n >= T);
      int ncyc = timed_out ? T : wait_n + 1;
      logic [31:0] exp_rd = (we || timed_out) ? 32'd0 : model_rd(sz, addr, rd);
      core_req  = 1'b1;
      core_we   = we;
      core_size = sz;
      core_addr = addr;
      core_wd   = wd;
      mem_ready = 1'($urandom % 2);   // ignored in IDLE
      mem_rd    = $urandom;
      #1;
      chk({tag, "_idle_misalign"}, 32'(misalign), 32'd0);
      chk({tag, "_idle_stall"},    32'(core_stall), 32'd1);
      chk({tag, "_idle_req"},      32'(mem_req), 32'd0);
      for (int k = 0; k < ncyc; k++) begin
         @(posedge clk); #2;
         // Scramble the core side: the bus must use latched values.
         core_we   = 1'($urandom % 2);
         core_size = 3'($urandom % 8);
         core_addr = $urandom;
         core_wd   = $urandom;
         mem_ready = (k == wait_n);
         mem_rd    = (k == wait_n) ? rd : $urandom;
         #1;
         chk($sformatf("%s_acc%0d_req", tag, k),   32'(mem_req), 32'd1);
         chk($sformatf("%s_acc%0d_we", tag, k),    32'(mem_we), 32'(we));
         chk($sformatf("%s_acc%0d_be", tag, k),    32'(mem_be), model_be(sz, addr));
         chk($sformatf("%s_acc%0d_addr", tag, k),  mem_addr, addr & 32'hFFFF_FFFC);
         chk($sformatf("%s_acc%0d_wd", tag, k),    mem_wd, model_wd(sz, wd));
         chk($sformatf("%s_acc%0d_stall", tag, k), 32'(core_stall), 32'd1);
      end
      @(posedge clk); #2;
      mem_ready = 1'($urandom % 2);   // ignored in RESP
      mem_rd    = $urandom;
      #1;
      chk({tag, "_resp_req"},   32'(mem_req), 32'd0);
      chk({tag, "_resp_be"},    32'(mem_be), 32'd0);
      chk({tag, "_resp_stall"}, 32'(core_stall), 32'd0);
      chk({tag, "_resp_err"},   32'(bus_err), 32'(timed_out));
      chk({tag, "_resp_rd"},    core_rd, exp_rd);
      core_req = 1'b0;
      @(posedge clk); #2;
      mem_ready = 1'b0;
      #1;
      chk({tag, "_post_err"},   32'(bus_err), 32'd0);
      chk({tag, "_post_req"},   32'(mem_req), 32'd0);
      chk({tag, "_post_stall"}, 32'(core_stall), 32'd0);
   endtask

   // A faulting request: flagged immediately, never issued, never stalls.
   task automatic bad(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                      input string tag);
      core_req  = 1'b1;
      core_we   = we;
      core_size = sz;
      core_addr = addr;
      core_wd   = $urandom;
      mem_ready = 1'b1;
      #1;
      chk({tag, "_misalign"}, 32'(misalign), 32'd1);
      chk({tag, "_stall"},    32'(core_stall), 32'd0);
      chk({tag, "_req"},      32'(mem_req), 32'd0);
      @(posedge clk); #2;
      chk({tag, "_req_next"},      32'(mem_req), 32'd0);
      chk({tag, "_misalign_next"}, 32'(misalign), 32'd1);
      core_req  = 1'b0;
      mem_ready = 1'b0;
      #1;
      chk({tag, "_misalign_drop"}, 32'(misalign), 32'd0);
   endtask

   initial begin
      logic        we;
      logic [2:0]  sz;
      logic [31:0] addr;

      rst_n     = 1'b0;
      core_req  = 1'b0;
      core_we   = 1'b0;
      core_size = 3'd0;
      core_addr = 32'd0;
      core_wd   = 32'd0;
      mem_rd    = 32'd0;
      mem_ready = 1'b0;
      #12;
      chk("rst_req",   32'(mem_req), 32'd0);
      chk("rst_we",    32'(mem_we), 32'd0);
      chk("rst_be",    32'(mem_be), 32'd0);
      chk("rst_addr",  mem_addr, 32'd0);
      chk("rst_wd",    mem_wd, 32'd0);
      chk("rst_err",   32'(bus_err), 32'd0);
      chk("rst_rd",    core_rd, 32'd0);
      chk("rst_stall", 32'(core_stall), 32'd0);
      core_req  = 1'b1;
      core_size = 3'd2;
      core_addr = 32'h40;
      #1;
      chk("rst_stall_req", 32'(core_stall), 32'd1);
      chk("rst_req_held",  32'(mem_req), 32'd0);
      core_req = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;

      // Directed cases
      txn(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, "lw");
      txn(1'b0, 3'd0, 32'h203, 32'h0, 32'h80FF_FFFF, 0, "lb");
      txn(1'b0, 3'd4, 32'h203, 32'h0, 32'h80FF_FFFF, 1, "lbu");
      txn(1'b1, 3'd1, 32'h102, 32'h1234_ABCD, 32'h7777_7777, 3, "sh");
      bad(1'b0, 3'd2, 32'h101, "lw_mis");
      bad(1'b0, 3'd1, 32'h003, "lh_mis");
      bad(1'b0, 3'd3, 32'h000, "size3");
      txn(1'b0, 3'd2, 32'h300, 32'h0, 32'h55AA_55AA, T, "lw_timeout");
      txn(1'b0, 3'd2, 32'h304, 32'h0, 32'hCAFE_F00D, T - 1, "lw_last");
      txn(1'b0, 3'd5, 32'h0FE, 32'h0, 32'h9ABC_1234, 2, "lhu");
      txn(1'b0, 3'd1, 32'h0FE, 32'h0, 32'h9ABC_1234, 0, "lh");

      // Reset asserted between edges while in ACCESS
      core_req  = 1'b1;
      core_we   = 1'b0;
      core_size = 3'd2;
      core_addr = 32'h500;
      mem_ready = 1'b0;
      @(posedge clk); #2;
      chk("mid_rst_pre_req", 32'(mem_req), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req",   32'(mem_req), 32'd0);
      chk("mid_rst_be",    32'(mem_be), 32'd0);
      chk("mid_rst_addr",  mem_addr, 32'd0);
      chk("mid_rst_stall", 32'(core_stall), 32'd1);
      core_req = 1'b0;
      #1;
      chk("mid_rst_stall_idle", 32'(core_stall), 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;
      chk("post_rst_req", 32'(mem_req), 32'd0);
      txn(1'b0, 3'd2, 32'h504, 32'h0, 32'h0BAD_F00D, 0, "lw_after_rst");

      // Randomized traffic against the model
      for (int i = 0; i < 60; i++) begin
         we   = 1'($urandom % 2);
         sz   = 3'($urandom % 8);
         if (we && (sz == 3'd4 || sz == 3'd5)) sz = sz - 3'd4;
         addr = $urandom;
         if (is_fault(sz, addr))
            bad(we, sz, addr, $sformatf("r%0d_bad", i));
         else
            txn(we, sz, addr, $urandom, $urandom, int'($urandom % 6),
                $sformatf("r%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
